pll_rst_seq: RTL and testbench
==============================

# pll_rst_seq

Reset sequencer directly downstream of the audio rPLL. It runs on the 12 MHz reference clock, synchronises the PLL `lock` output and holds the PLL in reset after power-up. It qualifies lock as stable, then releases the core and USB domain resets in order. On lock-acquire timeout it re-pulses the PLL reset, and on lock loss it re-asserts all downstream resets.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 12: cycles `pll_reset` is held high per attempt (≥1).
- `LOCK_STABLE_CYCLES`, 1200: consecutive synchronised-lock-high cycles required (100 µs @ 12 MHz, ≥1).
- `LOCK_TIMEOUT_CYCLES`, 24000: cycles allowed in WAIT before retrying (must exceed `LOCK_STABLE_CYCLES`).
- `STAGE_GAP_CYCLES`, 16: cycles between `core_rst_n` and `usb_rst_n` release (≥1).

Ports:
- `clkin`, in, 1: 12 MHz reference clock, the same clock that feeds the PLL.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pll_lock`, in, 1: rPLL LOCK, asynchronous to `clkin`.
- `pll_reset`, out, 1: drives the rPLL RESET input, active high.
- `core_rst_n`, out, 1: core domain reset, active low. Each consumer domain re-synchronises it locally.
- `usb_rst_n`, out, 1: USB/ULPI domain reset, active low.
- `ready`, out, 1: high only in RUN.
- `retry_cnt`, out, 8: number of lock-acquire timeouts, saturating at 255.
- `loss_cnt`, out, 8: number of lock losses after release, saturating at 255.

## Operation
- Lock synchroniser: two flops, `pll_lock` → `s1` → `lock_s`. Both flops reset to 0. The FSM uses only `lock_s`.
- States are PLLRST, WAIT, REL, RUN. Asynchronous reset enters PLLRST with all counters at 0.
- **PLLRST:**
  - `pll_reset` is 1.
  - The counter runs `PLL_RST_CYCLES` edges, then the FSM goes to WAIT and clears the stable and timeout counters.
- **WAIT:**
  - The timeout counter increments on every edge.
  - The stable counter increments when `lock_s`=1 and is cleared when `lock_s`=0.
  - On the edge where the stable count reaches `LOCK_STABLE_CYCLES`, the FSM goes to REL.
  - On the edge where the timeout count reaches `LOCK_TIMEOUT_CYCLES`, the FSM goes to PLLRST and `retry_cnt` increments.
  - If both happen on the same edge, stability wins: the FSM goes to REL and `retry_cnt` is unchanged.
- **REL:**
  - `core_rst_n` is 1.
  - The gap counter runs `STAGE_GAP_CYCLES` edges, then the FSM goes to RUN.
- **RUN:** `core_rst_n`, `usb_rst_n` and `ready` are all 1.
- **Lock loss:**
  - Applies when `lock_s`=0 is sampled in REL or RUN.
  - On that edge the FSM goes to WAIT with its counters cleared, and `loss_cnt` increments.
  - `core_rst_n`, `usb_rst_n` and `ready` go to 0 on the same edge.
  - `pll_reset` is not pulsed; the WAIT timeout handles a PLL that stays unlocked.
- A `lock_s` glitch inside WAIT only clears the stable counter. It does not count as a loss.
- Both event counters saturate at 255 and never wrap. They are cleared only by `rst_n`.
- Counter widths are `$clog2(param+1)` bits, and all comparisons are unsigned.

## Timing
- **Reset values:**
  - `pll_reset`=1.
  - `core_rst_n`=0 and `usb_rst_n`=0.
  - `ready`=0.
  - `retry_cnt`=0 and `loss_cnt`=0.
  - Reset assertion takes effect asynchronously on all outputs. Deassertion is sampled on the next `clkin` rising edge.
- All outputs are registered, with no combinational path from an input to an output.
- **PLL reset:** after `rst_n` deasserts, `pll_reset` falls on rising edge E = `PLL_RST_CYCLES`, counting the first edge after deassertion as edge 1.
- **Lock synchroniser:** if `pll_lock` is high at edge N, then `lock_s` is high from edge N+1.
- **Release latency:**
  - With `lock_s` steady high in WAIT, `core_rst_n` rises at edge N+1+`LOCK_STABLE_CYCLES`.
  - `usb_rst_n` and `ready` rise `STAGE_GAP_CYCLES` edges after `core_rst_n`.
- **Loss latency:** a `pll_lock` fall sampled at edge M drops all three release outputs at edge M+2.
- **Retry timing:**
  - A timeout at edge T raises `pll_reset` and increments `retry_cnt` on edge T.
  - `pll_reset` is then held high for `PLL_RST_CYCLES` edges.
- A mid-operation `rst_n` assertion always returns the block to PLLRST with the reset values above.

## Test plan
Benches use `PLL_RST_CYCLES`=3, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32 and `STAGE_GAP_CYCLES`=4.

1. Clean bring-up:
   - Stimulus: release `rst_n`; raise `pll_lock` at edge 5 and hold it.
   - Required: `pll_reset` falls at edge 3; `core_rst_n` rises at edge 14; `usb_rst_n` and `ready` rise at edge 18; both counters read 0.
2. Lock glitch in WAIT:
   - Stimulus: hold lock high for 6 cycles, low for 1 cycle, then high.
   - Required: the stable count restarts; `core_rst_n` rises 8 cycles after the second `lock_s` rise; `loss_cnt`=0.
3. Timeout and retry:
   - Stimulus: hold `pll_lock`=0.
   - Required: `pll_reset` re-rises every 35 edges (32 WAIT + 3 PLLRST); `retry_cnt` reaches 1, 2, 3 in turn; after more than 255 timeouts it reads 255.
4. Lock loss in RUN:
   - Stimulus: drop `pll_lock` for one cycle at edge M.
   - Required: `core_rst_n`, `usb_rst_n` and `ready` go 0 at edge M+2; `loss_cnt`=1; re-release follows after 8 stable cycles plus the gap; no `pll_reset` pulse.
5. Loss during REL:
   - Stimulus: drop lock 2 cycles after `core_rst_n` rises.
   - Required: `usb_rst_n` never rises; `core_rst_n` returns to 0; `loss_cnt` increments.
6. Async reset in RUN:
   - Stimulus: assert `rst_n`=0 mid-cycle.
   - Required: all outputs take their reset values immediately, without waiting for a clock edge; the bring-up sequence of test 1 then repeats.

Source files
------------

// File: rtl/pll_rst_seq.sv
// Reset sequencer for the audio rPLL. It runs on the 12 MHz reference clock
// and holds the PLL in reset after power-up. Once the synchronised lock has
// stayed high long enough, it releases the core reset and then the USB reset.
// A lock-acquire timeout re-pulses the PLL reset. A lock loss after release
// drops the downstream resets again without pulsing the PLL reset.
module pll_rst_seq #(
  parameter int unsigned PLL_RST_CYCLES      = 12,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1200,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 24000,
  parameter int unsigned STAGE_GAP_CYCLES    = 16
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       core_rst_n,
  output logic       usb_rst_n,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] ST_PLLRST = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_REL    = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  localparam int PW = $clog2(PLL_RST_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP_CYCLES + 1);

  // Each counter exits its state on the edge where it would reach its target,
  // so the compare value is target-1.
  localparam logic [PW-1:0] PLL_LAST    = PW'(PLL_RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP_CYCLES - 1);

  logic          s1;
  logic          lock_s;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          retry_inc;
  logic          loss_inc;
  logic [PW-1:0] pll_cnt;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;

  assign fsm_state = state;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      s1     <= pll_lock;
      lock_s <= s1;
    end
  end

  // Next-state decode. Stability beats timeout, and lock loss beats gap completion.
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state)
      ST_PLLRST: begin
        if (pll_cnt == PLL_LAST) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (lock_s && (stable_cnt == STABLE_LAST)) begin
          state_nxt = ST_REL;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = ST_PLLRST;
          retry_inc = 1'b1;
        end
      end
      ST_REL: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT;
          loss_inc  = 1'b1;
        end else if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT;
          loss_inc  = 1'b1;
        end
      end
      default: state_nxt = ST_PLLRST;
    endcase
  end

  // State register. The outputs are decoded from the next state, so they are registered.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PLLRST;
      pll_reset  <= 1'b1;
      core_rst_n <= 1'b0;
      usb_rst_n  <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= state_nxt;
      pll_reset  <= (state_nxt == ST_PLLRST);
      core_rst_n <= (state_nxt == ST_REL) || (state_nxt == ST_RUN);
      usb_rst_n  <= (state_nxt == ST_RUN);
      ready      <= (state_nxt == ST_RUN);
    end
  end

  // Phase counters. Every state change clears them all; otherwise only the
  // counters that belong to the current state advance.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pll_cnt    <= '0;
      stable_cnt <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
    end else if (state_nxt != state) begin
      pll_cnt    <= '0;
      stable_cnt <= '0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        ST_PLLRST: pll_cnt <= pll_cnt + PW'(1);
        ST_WAIT: begin
          to_cnt     <= to_cnt + TW'(1);
          stable_cnt <= lock_s ? stable_cnt + SW'(1) : '0;
        end
        ST_REL:  gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

  // Saturating event counters. Only rst_n clears them.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= 8'd0;
      loss_cnt  <= 8'd0;
    end else begin
      if (retry_inc && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'd1;
      if (loss_inc && (loss_cnt != 8'hFF))   loss_cnt  <= loss_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq with small timing parameters. Each test builds a
// per-edge table of {lock input, expected outputs}. Expectations are pushed
// when the lock value for an edge is driven. They are popped and compared
// half a clock later, once the DUT has updated its outputs.
module tb_pll_rst_seq;

  localparam int W = 20;

  logic       clkin;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic       core_rst_n;
  logic       usb_rst_n;
  logic       ready;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [1:0] fsm_state;

  typedef struct {
    logic         lock;
    logic [W-1:0] exp;
    bit           chk;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  pll_rst_seq #(
    .PLL_RST_CYCLES     (3),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .STAGE_GAP_CYCLES   (4)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .core_rst_n(core_rst_n),
    .usb_rst_n (usb_rst_n),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .fsm_state (fsm_state)
  );

  // Clock and watchdog
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pack(input logic pr, input logic core,
                                        input logic usb, input logic rdy,
                                        input int retry, input int loss);
    return {pr, core, usb, rdy, 8'(retry), 8'(loss)};
  endfunction

  // Scoreboard: pop one expectation and compare it with the DUT outputs
  task automatic check_out(input string name, input int idx);
    logic [W-1:0] exp;
    logic [W-1:0] act;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d]: got empty expected queue, want one entry", name, idx);
      return;
    end
    exp = exp_q.pop_front();
    act = {pll_reset, core_rst_n, usb_rst_n, ready, retry_cnt, loss_cnt};
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got pr=%b core=%b usb=%b rdy=%b retry=%0d loss=%0d, want pr=%b core=%b usb=%b rdy=%b retry=%0d loss=%0d",
               name, idx, act[19], act[18], act[17], act[16], act[15:8], act[7:0],
               exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  // Driver: apply lock before one rising edge, then check on the falling edge
  task automatic step(input logic lock, input logic [W-1:0] exp, input bit chk,
                      input string name, input int idx);
    pll_lock = lock;
    if (chk) exp_q.push_back(exp);
    @(posedge clkin);
    @(negedge clkin);
    if (chk) check_out(name, idx);
  endtask

  task automatic apply_table(input string name, input int first_idx);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].lock, tbl[i].exp, tbl[i].chk, name, first_idx + i);
  endtask

  // Assert rst_n between edges and check the reset values right away, with
  // no clock edge in between. Then release rst_n on a falling edge, so the
  // next rising edge is edge 1.
  task automatic do_reset(input string name);
    @(posedge clkin);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(pack(1, 0, 0, 0, 0, 0));
    check_out(name, 0);
    repeat (2) @(negedge clkin);
    exp_q.push_back(pack(1, 0, 0, 0, 0, 0));
    check_out(name, 1);
    rst_n = 1'b1;
  endtask

  function automatic void build_bringup();
    tbl.delete();
    for (int e = 1; e <= 20; e++)
      tbl.push_back('{lock: (e >= 5),
                      exp: pack((e < 3), (e >= 14), (e >= 18), (e >= 18), 0, 0),
                      chk: 1'b1});
  endfunction

  int rt;
  int ls;

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    repeat (2) @(negedge clkin);
    exp_q.push_back(pack(1, 0, 0, 0, 0, 0));
    check_out("reset_init", 0);
    rst_n = 1'b1;

    // Clean bring-up with lock raised at edge 5
    build_bringup();
    apply_table("bringup", 1);

    // One-cycle lock drop in RUN at relative edge 0
    tbl.delete();
    for (int r = 0; r <= 16; r++)
      tbl.push_back('{lock: (r != 0),
                      exp: pack(0, (r < 2) || (r >= 10), (r < 2) || (r >= 14),
                                (r < 2) || (r >= 14), 0, (r >= 2) ? 1 : 0),
                      chk: 1'b1});
    apply_table("loss_run", 0);

    // Drop in RUN, then a drop 2 cycles after core_rst_n rises. That second
    // loss lands on the edge where the gap would have ended.
    tbl.delete();
    for (int r = 0; r <= 30; r++) begin
      ls = (r >= 14) ? 3 : ((r >= 2) ? 2 : 1);
      tbl.push_back('{lock: !(r == 0 || r == 12),
                      exp: pack(0, (r < 2) || (r >= 10 && r < 14) || (r >= 22),
                                (r < 2) || (r >= 26), (r < 2) || (r >= 26), 0, ls),
                      chk: 1'b1});
    end
    apply_table("loss_rel", 0);

    // Async reset in RUN clears everything, then bring-up repeats
    do_reset("reset_run");
    build_bringup();
    apply_table("bringup2", 1);

    // Lock glitch in WAIT: high at edges 5..10, low at 11, high from 12
    do_reset("reset_glitch");
    tbl.delete();
    for (int e = 1; e <= 27; e++)
      tbl.push_back('{lock: (e >= 5 && e <= 10) || (e >= 12),
                      exp: pack((e < 3), (e >= 21), (e >= 25), (e >= 25), 0, 0),
                      chk: 1'b1});
    apply_table("glitch", 1);

    // No lock: retries every 35 edges, retry_cnt saturates at 255
    do_reset("reset_timeout");
    tbl.delete();
    for (int e = 1; e <= 9035; e++) begin
      rt = (e < 35) ? 0 : ((e - 35) / 35 + 1);
      if (rt > 255) rt = 255;
      tbl.push_back('{lock: 1'b0,
                      exp: pack((e < 3) || (e >= 35 && ((e - 35) % 35) < 3), 0, 0, 0, rt, 0),
                      chk: (e <= 110) || (e >= 8900)});
    end
    apply_table("timeout", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
